// File: rtl/req_mutex_pkg.sv
// Shared types and helpers for the request mutual-exclusion monitor.
package req_mutex_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        TRIPPED = 2'd2
    } state_e;

    // Bits needed to hold a count of 0..n set request lines.
    function automatic int pc_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/req_mutex_monitor_popcount.sv
// Combinational population count of the sampled request vector.
module req_popcount
    import req_mutex_pkg::*;
#(
    parameter int N_CH = 2
) (
    input  logic [N_CH-1:0]           req,
    output logic [pc_width(N_CH)-1:0] count
);

    localparam int PC_W = pc_width(N_CH);

    always_comb begin
        count = '0;
        for (int i = 0; i < N_CH; i++) begin
            count = count + PC_W'(req[i]);
        end
    end

endmodule

// File: rtl/req_mutex_monitor.sv
// Run-time mutual-exclusion checker over N_CH request lines.
// Define REQ_MUTEX_TURNAROUND_EN to also flag back-to-back ownership switches.
//
// state   | meaning
// IDLE    | out of reset or cleared while disabled, not yet checking
// ARMED   | checking, no violation since last clear
// TRIPPED | violation captured, further violations only counted
module req_mutex_monitor
    import req_mutex_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int MAX_ACTIVE = 1,
    parameter int CNT_W      = 8,
    parameter int TS_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [N_CH-1:0]   req,
    output logic              viol,
    output logic              viol_sticky,
    output logic [N_CH-1:0]   first_vec,
    output logic [TS_W-1:0]   first_ts,
    output logic [CNT_W-1:0]  viol_cnt,
    output logic [1:0]        state
);

    localparam int PC_W = pc_width(N_CH);

    state_e            st;
    logic [TS_W-1:0]   ts;
    logic [PC_W-1:0]   active;
    logic              over;
    logic              hit;
    logic [CNT_W-1:0]  cnt_inc;

    req_popcount #(.N_CH(N_CH)) u_popcount (
        .req   (req),
        .count (active)
    );

    assign over = 32'(active) > 32'(MAX_ACTIVE);

`ifdef REQ_MUTEX_TURNAROUND_EN
    logic [N_CH-1:0] prev_req;
    logic            turn;

    // A disabled cycle counts as an idle cycle between owners.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_req <= '0;
        end else begin
            prev_req <= en ? req : '0;
        end
    end

    assign turn = (|prev_req) && (|req) && ~|(prev_req & req);
    assign hit  = en && (over || turn);
`else
    assign hit  = en && over;
`endif

    assign cnt_inc = (viol_cnt == '1) ? viol_cnt : viol_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else if (en) begin
            ts <= ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            viol        <= 1'b0;
            viol_sticky <= 1'b0;
            first_vec   <= '0;
            first_ts    <= '0;
            viol_cnt    <= '0;
        end else begin
            viol <= 1'b0;
            if (clr) begin
                st          <= en ? ARMED : IDLE;
                viol_sticky <= 1'b0;
                first_vec   <= '0;
                first_ts    <= '0;
                viol_cnt    <= '0;
            end else begin
                case (st)
                    IDLE: begin
                        if (en) st <= ARMED;
                    end
                    ARMED: begin
                        if (hit) begin
                            st          <= TRIPPED;
                            viol        <= 1'b1;
                            viol_sticky <= 1'b1;
                            first_vec   <= req;
                            first_ts    <= ts;
                            viol_cnt    <= cnt_inc;
                        end
                    end
                    TRIPPED: begin
                        if (hit) begin
                            viol     <= 1'b1;
                            viol_cnt <= cnt_inc;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign state = st;

    always @(posedge clk) begin
        if (rst_n && en) assert (!$isunknown(req));
    end

endmodule

// File: tb/tb_req_mutex_monitor.sv
// Randomised and directed bench for req_mutex_monitor against a cycle-level rule model.
module tb_req_mutex_monitor;
    import req_mutex_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic [1:0] req_a = '0;
    logic [3:0] req_b = '0;

    logic        a_viol, a_sticky;
    logic [1:0]  a_vec;
    logic [15:0] a_ts;
    logic [7:0]  a_cnt;
    logic [1:0]  a_state;

    logic        b_viol, b_sticky;
    logic [3:0]  b_vec;
    logic [3:0]  b_ts;
    logic [1:0]  b_cnt;
    logic [1:0]  b_state;

    req_mutex_monitor #(.N_CH(2), .MAX_ACTIVE(1), .CNT_W(8), .TS_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .req(req_a),
        .viol(a_viol), .viol_sticky(a_sticky), .first_vec(a_vec),
        .first_ts(a_ts), .viol_cnt(a_cnt), .state(a_state)
    );

    req_mutex_monitor #(.N_CH(4), .MAX_ACTIVE(2), .CNT_W(2), .TS_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .req(req_b),
        .viol(b_viol), .viol_sticky(b_sticky), .first_vec(b_vec),
        .first_ts(b_ts), .viol_cnt(b_cnt), .state(b_state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: per-instance status held as plain integers.
    int maxa[2] = '{1, 2};
    int cmax[2] = '{255, 3};
    int tsm[2]  = '{65536, 16};
    int m_st[2], m_sticky[2], m_vec[2], m_fts[2], m_cnt[2], m_viol[2], m_ts[2], m_prev[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_sticky[i] = 0; m_vec[i] = 0; m_fts[i] = 0;
            m_cnt[i] = 0; m_viol[i] = 0; m_ts[i] = 0; m_prev[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input int r);
        bit bad;
        bad = en && ($countones(r) > maxa[i]);
`ifdef REQ_MUTEX_TURNAROUND_EN
        if (en && m_prev[i] != 0 && r != 0 && (m_prev[i] & r) == 0) bad = 1;
`endif
        m_prev[i] = en ? r : 0;
        m_viol[i] = 0;
        if (clr) begin
            m_st[i] = en ? 1 : 0;
            m_sticky[i] = 0; m_vec[i] = 0; m_fts[i] = 0; m_cnt[i] = 0;
        end else if (m_st[i] == 0) begin
            if (en) m_st[i] = 1;
        end else if (bad) begin
            if (m_st[i] == 1) begin
                m_st[i] = 2; m_sticky[i] = 1; m_vec[i] = r; m_fts[i] = m_ts[i];
            end
            m_viol[i] = 1;
            if (m_cnt[i] < cmax[i]) m_cnt[i]++;
        end
        if (en) m_ts[i] = (m_ts[i] + 1) % tsm[i];
    endtask

    task automatic check_all();
        chk("a.viol",   32'(a_viol),   m_viol[0]);
        chk("a.sticky", 32'(a_sticky), m_sticky[0]);
        chk("a.vec",    32'(a_vec),    m_vec[0]);
        chk("a.ts",     32'(a_ts),     m_fts[0]);
        chk("a.cnt",    32'(a_cnt),    m_cnt[0]);
        chk("a.state",  32'(a_state),  m_st[0]);
        chk("b.viol",   32'(b_viol),   m_viol[1]);
        chk("b.sticky", 32'(b_sticky), m_sticky[1]);
        chk("b.vec",    32'(b_vec),    m_vec[1]);
        chk("b.ts",     32'(b_ts),     m_fts[1]);
        chk("b.cnt",    32'(b_cnt),    m_cnt[1]);
        chk("b.state",  32'(b_state),  m_st[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, int'(req_a));
        model_step(1, int'(req_b));
        #1;
        check_all();
    endtask

    task automatic drive(input bit e, input bit c, input logic [1:0] ra, input logic [3:0] rb);
        en = e; clr = c; req_a = ra; req_b = rb;
        tick();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

`ifndef REQ_MUTEX_TURNAROUND_EN
        drive(1, 0, 2'b01, 4'b0000);
        drive(1, 0, 2'b10, 4'b0000);
        drive(1, 0, 2'b00, 4'b0110);
        chk("legal_viol", 32'(a_viol), 0);
        chk("legal_state", 32'(a_state), 32'(ARMED));
        chk("legal_cnt", 32'(a_cnt), 0);
        chk("b_legal_state", 32'(b_state), 32'(ARMED));
        drive(1, 0, 2'b11, 4'b0111);
        chk("first_viol", 32'(a_viol), 1);
        chk("first_vec", 32'(a_vec), 3);
        chk("first_ts", 32'(a_ts), 3);
        chk("first_cnt", 32'(a_cnt), 1);
        chk("first_state", 32'(a_state), 32'(TRIPPED));
        chk("b_first_vec", 32'(b_vec), 4'b0111);
        drive(1, 0, 2'b00, 4'b0000);
        chk("pulse_end", 32'(a_viol), 0);
        drive(1, 0, 2'b00, 4'b0000);
        drive(1, 0, 2'b00, 4'b0000);
        drive(1, 0, 2'b11, 4'b0000);
        chk("second_cnt", 32'(a_cnt), 2);
        chk("second_ts_frozen", 32'(a_ts), 3);
`else
        drive(1, 0, 2'b00, 4'b0000);
        drive(1, 0, 2'b01, 4'b0000);
        drive(1, 0, 2'b10, 4'b0000);
        chk("turn_viol", 32'(a_viol), 1);
        chk("turn_vec", 32'(a_vec), 2'b10);
        drive(1, 1, 2'b00, 4'b0000);
        drive(1, 0, 2'b01, 4'b0000);
        drive(1, 0, 2'b00, 4'b0000);
        drive(1, 0, 2'b10, 4'b0000);
        chk("gap_no_viol", 32'(a_sticky), 0);
`endif

        for (int k = 0; k < 5; k++) drive(1, 0, 2'b00, 4'b1111);
        chk("sat_cnt", 32'(b_cnt), 3);
        drive(1, 1, 2'b11, 4'b1111);
        chk("clr_cnt", 32'(a_cnt), 0);
        chk("clr_sticky", 32'(a_sticky), 0);
        chk("clr_viol", 32'(a_viol), 0);
        chk("clr_state", 32'(a_state), 32'(ARMED));
        chk("clr_b_cnt", 32'(b_cnt), 0);

        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 2'b11, 4'b1111);
            chk("dis_viol", 32'(a_viol), 0);
        end
        drive(1, 0, 2'b11, 4'b0000);
`ifndef REQ_MUTEX_TURNAROUND_EN
        chk("ts_frozen", 32'(a_ts), 14);
`endif

        for (int k = 0; k < 600; k++) begin
            logic [1:0] ra;
            logic [3:0] rb;
            ra = 2'($urandom_range(0, 3));
            rb = 4'($urandom_range(0, 15));
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, ra, rb);
        end

        drive(1, 0, 2'b11, 4'b1111);
        drive(1, 0, 2'b11, 4'b1111);
        chk("pre_rst_state", 32'(a_state), 32'(TRIPPED));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_state", 32'(a_state), 32'(IDLE));
        chk("async_sticky", 32'(a_sticky), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/req_mutex_monitor.md
Name: req_mutex_monitor

Overview:
- Synthesizable run-time checker that enforces mutual exclusion across N request lines, e.g. rd/wr strobes or multi-master bus requests.
- Generalises the rule "read and write request must not occur at same time" to N channels with a configurable number of simultaneously active requests.
- Captures the first violation (channel vector and timestamp) and keeps a saturating violation count.
- Sits beside the protected interface; its outputs feed status registers or an interrupt line.

Parameters:
N_CH, 2, number of request channels monitored (min 2)
MAX_ACTIVE, 1, maximum requests allowed high in the same cycle (1 means strict mutual exclusion)
CNT_W, 8, width of the saturating violation counter
TS_W, 16, width of the cycle timestamp counter

Ports:
clk  in  1  system clock, all sampling on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  monitoring enable; when low, no checks and no timestamp advance
clr  in  1  synchronous clear of sticky status, capture registers and counter
req  in  N_CH  request lines sampled each cycle
viol  out  1  registered one-cycle pulse per violating sample
viol_sticky  out  1  set on first violation, held until clr
first_vec  out  N_CH  req vector of the first violation since clear
first_ts  out  TS_W  timestamp of the first violation since clear
viol_cnt  out  CNT_W  number of violating cycles, saturates at all-ones
state  out  2  FSM state encoding (see package)

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; state = IDLE; timestamp = 0.
- Violation condition: en high and popcount(req) > MAX_ACTIVE in the sampled cycle.
- Latency: the violation is sampled at edge k and appears on viol, viol_sticky, viol_cnt and the capture registers after edge k.
- FSM:
  - IDLE: entered from reset. Moves to ARMED on the first cycle en is high.
  - ARMED: monitoring, no violation seen. A violation moves it to TRIPPED and loads first_vec = req and first_ts = timestamp.
  - TRIPPED: further violations pulse viol and increment viol_cnt; first_vec and first_ts are frozen.
  - clr from ARMED or TRIPPED returns the FSM to ARMED if en is high, otherwise to IDLE.
  - en low in ARMED or TRIPPED holds state and all status. Checking resumes when en returns high.
- Timestamp: free-running TS_W counter that advances every cycle en is high. Wraps from all-ones to 0 with no flag.
- viol_cnt saturates at 2^CNT_W-1 and never wraps.
- clr and a violation in the same cycle: clr wins. Status clears, the violation is discarded, viol = 0 next cycle, and the FSM goes to ARMED.
- clr does not reset the timestamp.
- Reset asserted mid-violation: all outputs clear immediately (asynchronously).
- Exactly MAX_ACTIVE bits high is legal. All-zero req is legal.
- X/Z on req is not checked; simulation assertions cover that case.

Optional Feature:
- Macro: REQ_MUTEX_TURNAROUND_EN.
- When defined: a switch of ownership with no idle cycle is also a violation. The rule is: req at cycle k-1 nonzero, req at cycle k nonzero, and the two vectors have no common set bit (e.g. rd then wr back-to-back). It sets viol, counts, and is captured exactly like a concurrency violation.
- When undefined: only the concurrency rule is checked, and no previous-req register is synthesized.

Decomposition:
- Package req_mutex_pkg holds:
  - the state_e enum: IDLE=2'd0, ARMED=2'd1, TRIPPED=2'd2 (2'd3 unused and decoded to IDLE);
  - a localparam function that computes the popcount width from N_CH.
- One sub-module, req_popcount: a purely combinational, parametrised N_CH-input population count used by the violation comparator.

Test Plan:
- N_CH=2, MAX_ACTIVE=1; req=01, then 10, then 00 -> viol never asserts, state=ARMED, viol_cnt=0.
- req=11 at timestamp 3 -> viol pulses 1 cycle, viol_sticky=1, first_vec=11, first_ts=3, viol_cnt=1, state=TRIPPED. A second 11 at timestamp 7 -> viol_cnt=2, first_ts stays 3.
- N_CH=4, MAX_ACTIVE=2; req=0110 -> no violation. req=0111 -> violation, first_vec=0111.
- CNT_W=2; 5 violating cycles -> viol_cnt sticks at 3. Then clr together with req=11 -> viol_cnt=0, viol_sticky=0, viol=0, state=ARMED.
- en=0 with req=11 for 4 cycles -> no viol, timestamp frozen. Pull rst_n low mid-TRIPPED -> all outputs 0 and state=IDLE immediately, without waiting for a clock edge.
- With REQ_MUTEX_TURNAROUND_EN: req=01 then 10 on consecutive cycles -> viol, first_vec=10. req=01, 00, 10 -> no violation.
